// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus of instr_encoder.
// master: host/test port side; slave: the encoder itself.
interface instr_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_kind;
   logic [2:0]        req_alu;
   logic [4:0]        req_rd;
   logic [4:0]        req_rs1;
   logic [4:0]        req_rs2;
   logic [12:0]       req_imm;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err;

   modport master (
      output req_valid, req_kind, req_alu, req_rd, req_rs1, req_rs2, req_imm,
      input  req_ready, imem_we, imem_addr, imem_wdata, count, full, err
   );

   modport slave (
      input  req_valid, req_kind, req_alu, req_rd, req_rs1, req_rs2, req_imm,
      output req_ready, imem_we, imem_addr, imem_wdata, count, full, err
   );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: turns field-level RV32I requests into instruction words and
// writes them sequentially into instruction memory, one word per cycle.
// Optional feature macro: ENC_BRANCH_EN (BEQ encoding; when undefined,
// kind 4 is treated as an illegal request).
module instr_encoder #(
   parameter int ADDR_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   instr_encoder_if.slave bus
);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(1) << ADDR_W;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
`ifdef ENC_BRANCH_EN
   localparam logic [6:0] OP_B  = 7'b1100011;
`endif

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, full_d;
   logic              err_q, err_d;

   logic              legal;
   logic [31:0]       word;
   logic              alu_ok;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic              last_write;
   logic              ready;
   logic              accept;
   logic              commit;

`ifndef ENC_BRANCH_EN
   // Branch offset MSB only feeds the BEQ format, which is compiled out here.
   logic unused_imm12;
   assign unused_imm12 = bus.req_imm[12];
`endif

   // Encode the request into a word and classify it as legal/illegal.
   always_comb begin
      alu_ok = 1'b1;
      f3     = 3'b000;
      f7     = 7'b0000000;
      unique case (bus.req_alu)
         3'b000:  f3 = 3'b000;
         3'b001:  begin f3 = 3'b000; f7 = 7'b0100000; end
         3'b010:  f3 = 3'b111;
         3'b011:  f3 = 3'b110;
         3'b101:  f3 = 3'b010;
         default: alu_ok = 1'b0;
      endcase

      legal = 1'b0;
      word  = '0;
      case (bus.req_kind)
         3'd0: begin
            legal = alu_ok;
            word  = {f7, bus.req_rs2, bus.req_rs1, f3, bus.req_rd, OP_R};
         end
         3'd1: begin
            // sub has no immediate form
            legal = alu_ok && (bus.req_alu != 3'b001);
            word  = {bus.req_imm[11:0], bus.req_rs1, f3, bus.req_rd, OP_I};
         end
         3'd2: begin
            legal = 1'b1;
            word  = {bus.req_imm[11:0], bus.req_rs1, 3'b010, bus.req_rd, OP_LW};
         end
         3'd3: begin
            legal = 1'b1;
            word  = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, 3'b010,
                     bus.req_imm[4:0], OP_SW};
         end
`ifdef ENC_BRANCH_EN
         3'd4: begin
            // branch offsets are halfword-aligned; bit 0 is not encodable
            legal = !bus.req_imm[0];
            word  = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1,
                     3'b000, bus.req_imm[4:1], bus.req_imm[11], OP_B};
         end
`endif
         default: begin
            legal = 1'b0;
            word  = '0;
         end
      endcase
   end

   // Handshake, pointer/count advance, FSM next state and clear handling.
   always_comb begin
      last_write = (count_q + (ADDR_W+1)'(1)) == DEPTH_C;
      ready      = !rst && !clr && (state_q != S_FULL) &&
                   !((state_q == S_WRITE) && last_write);
      accept     = bus.req_valid && ready;
      commit     = (state_q == S_WRITE);

      count_d = count_q + (ADDR_W+1)'(commit);
      // hold the pointer on the final write so it never wraps
      addr_d  = (commit && !last_write) ? addr_q + ADDR_W'(1) : addr_q;
      wdata_d = (accept && legal) ? word : wdata_q;
      err_d   = err_q | (accept && !legal);

      if (accept && legal)
         state_d = S_WRITE;
      else if ((commit && last_write) || (state_q == S_FULL))
         state_d = S_FULL;
      else
         state_d = S_IDLE;

      full_d = (count_d == DEPTH_C);

      if (clr) begin
         state_d = S_IDLE;
         addr_d  = '0;
         count_d = '0;
         err_d   = 1'b0;
         full_d  = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
         full_q  <= full_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready  = ready;
   // A write cycle coinciding with rst/clr is dropped.
   assign bus.imem_we    = (state_q == S_WRITE) && !rst && !clr;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.count      = count_q;
   assign bus.full       = full_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (ADDR_W=8 and ADDR_W=2 copies).
module tb_instr_encoder;
   logic clk = 1'b0;
   logic rst;
   logic clr_a;
   logic clr_b;
   int   errors = 0;
   int   checks = 0;
   int   sent;
   int   wr;
   logic acc;
   logic [31:0] b_words [5];

   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(8)) if_a ();
   instr_encoder_if #(.ADDR_W(2)) if_b ();

   instr_encoder #(.ADDR_W(8)) dut_a (.clk(clk), .rst(rst), .clr(clr_a), .bus(if_a.slave));
   instr_encoder #(.ADDR_W(2)) dut_b (.clk(clk), .rst(rst), .clr(clr_b), .bus(if_b.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req_a(input logic [2:0] k, input logic [2:0] a, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
      if_a.req_kind  = k;
      if_a.req_alu   = a;
      if_a.req_rd    = rd;
      if_a.req_rs1   = rs1;
      if_a.req_rs2   = rs2;
      if_a.req_imm   = imm;
      if_a.req_valid = 1'b1;
   endtask

   task automatic req_b(input logic [4:0] rd);
      if_b.req_kind  = 3'd0;
      if_b.req_alu   = 3'b000;
      if_b.req_rd    = rd;
      if_b.req_rs1   = 5'd1;
      if_b.req_rs2   = 5'd2;
      if_b.req_imm   = '0;
      if_b.req_valid = 1'b1;
   endtask

   initial begin
      b_words[0] = 32'h002080B3;
      b_words[1] = 32'h00208133;
      b_words[2] = 32'h002081B3;
      b_words[3] = 32'h00208233;
      b_words[4] = 32'h002082B3;
      rst = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
      req_a(0, 0, 0, 0, 0, 0); if_a.req_valid = 1'b0;
      req_b(0);                if_b.req_valid = 1'b0;

      // reset state
      step; step;
      chk("rst_ready", if_a.req_ready, 0);
      chk("rst_we", if_a.imem_we, 0);
      chk("rst_addr", if_a.imem_addr, 0);
      chk("rst_wdata", if_a.imem_wdata, 0);
      chk("rst_count", if_a.count, 0);
      chk("rst_full", if_a.full, 0);
      chk("rst_err", if_a.err, 0);
      rst = 1'b0; #1;
      chk("post_rst_ready", if_a.req_ready, 1);

      // R add x3,x1,x2
      req_a(0, 3'b000, 3, 1, 2, 0);
      step; if_a.req_valid = 1'b0;
      chk("add_we", if_a.imem_we, 1);
      chk("add_addr", if_a.imem_addr, 0);
      chk("add_wdata", if_a.imem_wdata, 32'h002081B3);
      step;
      chk("add_we_off", if_a.imem_we, 0);
      chk("add_count", if_a.count, 1);
      chk("add_hold", if_a.imem_wdata, 32'h002081B3);

      // clr, then back-to-back LW / SW
      clr_a = 1'b1; step; clr_a = 1'b0;
      chk("clr_count", if_a.count, 0);
      chk("clr_addr", if_a.imem_addr, 0);
      req_a(2, 0, 5, 0, 0, 13'd8);
      step;
      req_a(3, 0, 0, 1, 6, 13'd4);
      chk("lw_we", if_a.imem_we, 1);
      chk("lw_addr", if_a.imem_addr, 0);
      chk("lw_wdata", if_a.imem_wdata, 32'h00802283);
      step; if_a.req_valid = 1'b0;
      chk("sw_we", if_a.imem_we, 1);
      chk("sw_addr", if_a.imem_addr, 1);
      chk("sw_wdata", if_a.imem_wdata, 32'h0060A223);
      step;
      chk("lwsw_count", if_a.count, 2);

      // BEQ x1,x2,-8
      req_a(4, 0, 0, 1, 2, 13'h1FF8);
      step; if_a.req_valid = 1'b0;
`ifdef ENC_BRANCH_EN
      chk("beq_we", if_a.imem_we, 1);
      chk("beq_addr", if_a.imem_addr, 2);
      chk("beq_wdata", if_a.imem_wdata, 32'hFE208CE3);
      chk("beq_err", if_a.err, 0);
      step;
      chk("beq_count", if_a.count, 3);
`else
      chk("beq_we", if_a.imem_we, 0);
      chk("beq_err", if_a.err, 1);
      step;
      chk("beq_count", if_a.count, 2);
`endif

      // request presented together with clr is not accepted
      clr_a = 1'b1;
      req_a(0, 3'b000, 3, 1, 2, 0);
      #1;
      chk("clr_ready", if_a.req_ready, 0);
      step; clr_a = 1'b0; if_a.req_valid = 1'b0;
      chk("clr_req_we", if_a.imem_we, 0);
      chk("clr2_count", if_a.count, 0);
      chk("clr2_err", if_a.err, 0);

      // illegal I-ALU sub, then legal I-ALU and
      req_a(1, 3'b001, 7, 4, 0, 0);
      #1;
      chk("isub_ready", if_a.req_ready, 1);
      step; if_a.req_valid = 1'b0;
      chk("isub_we", if_a.imem_we, 0);
      chk("isub_err", if_a.err, 1);
      chk("isub_ready_after", if_a.req_ready, 1);
      req_a(1, 3'b010, 7, 4, 0, 13'h0FF);
      step; if_a.req_valid = 1'b0;
      chk("andi_we", if_a.imem_we, 1);
      chk("andi_addr", if_a.imem_addr, 0);
      chk("andi_wdata", if_a.imem_wdata, 32'h0FF27393);
      step;
      chk("andi_count", if_a.count, 1);
      chk("andi_err_sticky", if_a.err, 1);

      // more illegal requests: kind 5, bad ALU code, odd branch offset
      req_a(5, 0, 1, 1, 1, 0);
      step; if_a.req_valid = 1'b0;
      chk("kind5_we", if_a.imem_we, 0);
      req_a(0, 3'b100, 1, 1, 1, 0);
      step; if_a.req_valid = 1'b0;
      chk("alu4_we", if_a.imem_we, 0);
      req_a(4, 0, 0, 1, 2, 13'h0009);
      step; if_a.req_valid = 1'b0;
      chk("beq_odd_we", if_a.imem_we, 0);
      step;
      chk("illegal_count", if_a.count, 1);
      chk("illegal_addr", if_a.imem_addr, 1);

      // back-to-back sub, slt, or
      req_a(0, 3'b001, 1, 2, 3, 0);
      step;
      req_a(0, 3'b101, 10, 11, 12, 0);
      chk("sub_addr", if_a.imem_addr, 1);
      chk("sub_wdata", if_a.imem_wdata, 32'h403100B3);
      step;
      req_a(0, 3'b011, 3, 1, 2, 0);
      chk("slt_addr", if_a.imem_addr, 2);
      chk("slt_wdata", if_a.imem_wdata, 32'h00C5A533);
      step; if_a.req_valid = 1'b0;
      chk("or_we", if_a.imem_we, 1);
      chk("or_addr", if_a.imem_addr, 3);
      chk("or_wdata", if_a.imem_wdata, 32'h0020E1B3);
      step;
      chk("alu_count", if_a.count, 4);

      // rst during a WRITE cycle drops the word
      req_a(0, 3'b000, 3, 1, 2, 0);
      step; if_a.req_valid = 1'b0; rst = 1'b1; #1;
      chk("rstw_we", if_a.imem_we, 0);
      chk("rstw_ready", if_a.req_ready, 0);
      step; rst = 1'b0; #1;
      chk("rstw_we_after", if_a.imem_we, 0);
      chk("rstw_addr", if_a.imem_addr, 0);
      chk("rstw_wdata", if_a.imem_wdata, 0);
      chk("rstw_count", if_a.count, 0);
      chk("rstw_err", if_a.err, 0);
      chk("rstw_full", if_a.full, 0);
      chk("rstw_ready_after", if_a.req_ready, 1);

      // ADDR_W=2: five back-to-back requests fill the 4-word memory
      sent = 0; wr = 0;
      req_b(5'(sent + 1));
      for (int cyc = 0; cyc < 10; cyc++) begin
         acc = if_b.req_valid && if_b.req_ready;
         step;
         if (acc) sent++;
         if (if_b.imem_we) begin
            if (wr < 4) begin
               chk("b_addr", if_b.imem_addr, 64'(wr));
               chk("b_wdata", if_b.imem_wdata, b_words[wr]);
            end else begin
               chk("b_extra_write", 64'(wr), 3);
            end
            wr++;
         end
         if (sent < 5) req_b(5'(sent + 1));
      end
      chk("b_writes", 64'(wr), 4);
      chk("b_accepted", 64'(sent), 4);
      chk("b_count", if_b.count, 4);
      chk("b_full", if_b.full, 1);
      chk("b_ready", if_b.req_ready, 0);
      chk("b_we_idle", if_b.imem_we, 0);
      clr_b = 1'b1; if_b.req_valid = 1'b0;
      step; clr_b = 1'b0; #1;
      chk("b_clr_count", if_b.count, 0);
      chk("b_clr_full", if_b.full, 0);
      chk("b_clr_ready", if_b.req_ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
